aes_round_engine: RTL and testbench

- Iterative AES forward-cipher round engine that sequences its own rounds with an internal counter; no external state_in is needed.
- Number of rounds is parametrised (AES-128/192/256). The engine requests one round key per cycle by index from an external key store.
- Sits between the block-input FIFO and the ciphertext output stage.
- Valid/ready handshakes on both input and output sides; the result is held until the consumer takes it.

---
 rtl/aes_round_engine.sv | 154 +++++++++++++++
 tb/tb_aes_round_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// Iterative AES forward-cipher round engine. One round per cycle; round keys are fetched
// by index from an external key store. Valid/ready handshakes on input and output.
module aes_round_engine #(
  parameter int unsigned NR    = 10,
  parameter int unsigned IDX_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [127:0]     data_in,
  output logic [IDX_W-1:0] rk_idx_out,
  input  logic [127:0]     rk_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [127:0]     data_out,
  output logic             busy_out
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14");
  end
  if ((2 ** IDX_W) <= NR) begin : g_bad_idx_w
    $error("aes_round_engine: IDX_W too narrow to index round NR");
  end

  // Forward S-box, byte b at SBOX[b].
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StRun, StLast, StDone} state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  // Byte k = 4*col + row sits at [127-8k -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  state_e           state_q;
  logic [IDX_W-1:0] rnd_q;
  logic [127:0]     st_q;
  logic [127:0]     data_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [127:0]     sr_res;
  logic [127:0]     mc_res;
  logic [127:0]     pre_key;
  logic [127:0]     round_res;

  // Shared round datapath: IDLE whitens the input, LAST skips MixColumns.
  always_comb begin
    sr_res = shift_rows(sub_bytes(st_q));
    mc_res = mix_columns(sr_res);
    unique case (state_q)
      StIdle:  pre_key = data_in;
      StLast:  pre_key = sr_res;
      default: pre_key = mc_res;
    endcase
    round_res = add_round_key(pre_key, rk_in);
  end

  // Control FSM, round counter, state and output registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= StIdle;
      rnd_q       <= '0;
      st_q        <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_in) begin
            st_q    <= round_res;
            rnd_q   <= IDX_W'(1);
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          st_q  <= round_res;
          rnd_q <= rnd_q + IDX_W'(1);
          if (rnd_q == IDX_W'(NR - 1)) state_q <= StLast;
        end
        StLast: begin
          data_q      <= round_res;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready_in) begin
            out_valid_q <= 1'b0;
            rnd_q       <= '0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_out  = (state_q == StIdle);
  assign rk_idx_out    = rnd_q;
  assign out_valid_out = out_valid_q;
  assign data_out      = data_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: three instances (NR = 10, 12, 14) share clock, reset and
// plaintext bus; each has its own key store. Results are checked against an AES model.
module tb_aes_round_engine;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST;
  logic [127:0] data_in;
  logic         out_ready_in;
  logic [2:0]   in_valid;
  wire  [2:0]   in_ready;
  wire  [2:0]   out_valid;
  wire  [2:0]   busy;
  wire  [3:0]   rk_idx   [3];
  wire  [127:0] rk_in    [3];
  wire  [127:0] data_out [3];

  logic [127:0] rks [3][16];
  logic [7:0]   sbt [256];
  int           checks   = 0;
  int           failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_engine #(
      .NR    (10 + 2 * g),
      .IDX_W (4)
    ) u_dut (
      .CLK          (CLK),
      .RST          (RST),
      .in_valid_in  (in_valid[g]),
      .in_ready_out (in_ready[g]),
      .data_in      (data_in),
      .rk_idx_out   (rk_idx[g]),
      .rk_in        (rk_in[g]),
      .out_valid_out(out_valid[g]),
      .out_ready_in (out_ready_in),
      .data_out     (data_out[g]),
      .busy_out     (busy[g])
    );
    // Key store answers combinationally for the requested index.
    assign rk_in[g] = rks[g][rk_idx[g]];
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse followed by the affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbt[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  // Key expansion for instance g; key is left-aligned in 256 bits.
  task automatic fill_keys(input int g, input logic [255:0] key);
    int          nk;
    int          nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    nk   = 4 + 2 * g;
    nr   = 10 + 2 * g;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      rks[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input int g);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] k;
    logic [127:0] res;
    int           nr;
    nr = 10 + 2 * g;
    k  = rks[g][0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
          s[4*c+0] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
          s[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
          s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
          s[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
        end
      end
      k = rks[g][r];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One block through instance g, entered and left at a negedge with the engine idle.
  task automatic run_block(input int g, input logic [127:0] pt, input logic [127:0] exp,
                           input int hold, input string tag);
    int nr;
    int lat;
    bit seq_ok;
    bit hold_ok;
    nr = 10 + 2 * g;
    check({tag, " idle_ready"}, 128'(in_ready[g]), 128'd1);
    check({tag, " idle_idx"}, 128'(rk_idx[g]), 128'd0);
    data_in      = pt;
    in_valid[g]  = 1'b1;
    out_ready_in = 1'b0;
    @(negedge CLK);
    in_valid[g] = 1'b0;
    lat         = 0;
    seq_ok      = 1'b1;
    while (!out_valid[g] && lat < 40) begin
      if (rk_idx[g] !== 4'(lat + 1)) seq_ok = 1'b0;
      data_in = rand128();
      @(negedge CLK);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(nr));
    check({tag, " idx_seq"}, 128'(seq_ok), 128'd1);
    check({tag, " done_idx"}, 128'(rk_idx[g]), 128'(nr));
    check({tag, " data"}, data_out[g], exp);
    check({tag, " busy_done"}, 128'(busy[g]), 128'd1);
    check({tag, " ready_done"}, 128'(in_ready[g]), 128'd0);
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid[g] = 1'($urandom_range(0, 1));
      data_in     = rand128();
      @(negedge CLK);
      if (!(out_valid[g] === 1'b1 && data_out[g] === exp && in_ready[g] === 1'b0
            && rk_idx[g] === 4'(nr))) hold_ok = 1'b0;
    end
    in_valid[g] = 1'b0;
    if (hold > 0) check({tag, " hold_stable"}, 128'(hold_ok), 128'd1);
    out_ready_in = 1'b1;
    @(negedge CLK);
    out_ready_in = 1'b0;
    check({tag, " post_valid"}, 128'(out_valid[g]), 128'd0);
    check({tag, " post_ready"}, 128'(in_ready[g]), 128'd1);
    check({tag, " post_idx"}, 128'(rk_idx[g]), 128'd0);
    check({tag, " post_busy"}, 128'(busy[g]), 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [127:0] pt1, pt2, e1, e2, got0, got1;
    int           acc [$];
    logic [127:0] got [$];
    int           cyc;
    int           n;
    int           g;

    init_sbox();
    RST          = 1'b0;
    in_valid     = 3'b000;
    out_ready_in = 1'b0;
    data_in      = '0;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      check("reset valid", 128'(out_valid[i]), 128'd0);
      check("reset busy", 128'(busy[i]), 128'd0);
      check("reset data", data_out[i], 128'd0);
      check("reset ready", 128'(in_ready[i]), 128'd1);
      check("reset idx", 128'(rk_idx[i]), 128'd0);
    end
    RST = 1'b1;
    @(negedge CLK);

    // FIPS-197 appendix C vectors
    fill_keys(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    run_block(0, 128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, "c1_nr10");
    fill_keys(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    run_block(1, 128'h00112233445566778899aabbccddeeff,
              128'hdda97ca4864cdfe06eaf70a0ec0d7191, 0, "c2_nr12");
    fill_keys(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    run_block(2, 128'h00112233445566778899aabbccddeeff,
              128'h8ea2b7ca516745bfeafc49904b496089, 0, "c3_nr14");

    // Output backpressure for 20 cycles
    fill_keys(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    run_block(0, 128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 20, "backpressure");

    // Back-to-back with in_valid held high
    fill_keys(0, {rand128(), 128'h0});
    pt1          = rand128();
    pt2          = rand128();
    e1           = aes_enc(pt1, 0);
    e2           = aes_enc(pt2, 0);
    data_in      = pt1;
    in_valid[0]  = 1'b1;
    out_ready_in = 1'b1;
    cyc          = 0;
    while (got.size() < 2 && cyc < 80) begin
      if (in_ready[0] && in_valid[0]) acc.push_back(cyc);
      if (out_valid[0] && out_ready_in) got.push_back(data_out[0]);
      @(negedge CLK);
      cyc++;
      if (acc.size() == 1) data_in = pt2;
      else if (acc.size() >= 2) in_valid[0] = 1'b0;
    end
    in_valid[0]  = 1'b0;
    out_ready_in = 1'b0;
    got0 = (got.size() > 0) ? got[0] : 128'h0;
    got1 = (got.size() > 1) ? got[1] : 128'h0;
    check("b2b accepts", 128'(acc.size()), 128'd2);
    check("b2b interval", (acc.size() == 2) ? 128'(acc[1] - acc[0]) : 128'h0, 128'd12);
    check("b2b data1", got0, e1);
    check("b2b data2", got1, e2);

    // Reset in the middle of round 5
    fill_keys(0, {rand128(), 128'h0});
    data_in     = rand128();
    in_valid[0] = 1'b1;
    @(negedge CLK);
    in_valid[0] = 1'b0;
    n = 0;
    while (rk_idx[0] !== 4'd5 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("midrst reached_r5", 128'(rk_idx[0]), 128'd5);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst valid", 128'(out_valid[0]), 128'd0);
    check("midrst data", data_out[0], 128'd0);
    check("midrst ready", 128'(in_ready[0]), 128'd1);
    check("midrst busy", 128'(busy[0]), 128'd0);
    check("midrst idx", 128'(rk_idx[0]), 128'd0);
    RST = 1'b1;
    @(negedge CLK);
    pt1 = rand128();
    run_block(0, pt1, aes_enc(pt1, 0), 0, "after_rst");

    // Randomised keys, plaintexts and key sizes
    for (int i = 0; i < 6; i++) begin
      g = int'($urandom_range(0, 2));
      fill_keys(g, {rand128(), rand128()});
      pt1 = rand128();
      run_block(g, pt1, aes_enc(pt1, g), int'($urandom_range(0, 3)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
